// File: rtl/mmm_exp_ctrl_pkg.sv
// Shared encodings for the modular-exponentiation sequencer and its
// per-multiplication phase sequencer.
package mmm_exp_ctrl_pkg;

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_TO_MONT_X   = 3'd1;
   localparam logic [2:0] ST_TO_MONT_ONE = 3'd2;
   localparam logic [2:0] ST_SQUARE      = 3'd3;
   localparam logic [2:0] ST_MULT        = 3'd4;
   localparam logic [2:0] ST_FROM_MONT   = 3'd5;
   localparam logic [2:0] ST_DONE        = 3'd6;

   localparam logic [2:0] PH_IDLE   = 3'd0;
   localparam logic [2:0] PH_CLR    = 3'd1;
   localparam logic [2:0] PH_LOAD   = 3'd2;
   localparam logic [2:0] PH_ITER   = 3'd3;
   localparam logic [2:0] PH_CAPT   = 3'd4;
   localparam logic [2:0] PH_SAMPLE = 3'd5;

   // Wide constant 1; users slice it down to their operand width (<= 64).
   localparam logic [63:0] ONE_MAX = 64'd1;

endpackage

// File: rtl/mmm_op_seq.sv
// Steps the Montgomery multiplier through CLR/LOAD/ITER/CAPT/SAMPLE for one
// multiplication, chaining straight into the next one unless told it is the last.
module mmm_op_seq
   import mmm_exp_ctrl_pkg::*;
#(
   parameter int MMM_CYCLES = 10
) (
   input  logic i_clk,
   input  logic i_rstb,
   input  logic i_en,
   input  logic i_go,
   input  logic i_last,
   output logic o_sample,
   output logic o_mmm_en,
   output logic o_mmm_rst,
   output logic o_mmm_ld_a,
   output logic o_mmm_ld_r,
   output logic o_mmm_lock
);

   localparam int ITW = (MMM_CYCLES > 1) ? $clog2(MMM_CYCLES) : 1;
   localparam logic [ITW-1:0] ITER_LAST = ITW'(MMM_CYCLES - 1);

   logic [2:0]     r_phase;
   logic [ITW-1:0] r_iter;

   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         r_phase <= PH_IDLE;
         r_iter  <= '0;
      end else if (i_en) begin
         case (r_phase)
            PH_IDLE:   if (i_go) r_phase <= PH_CLR;
            PH_CLR:    r_phase <= PH_LOAD;
            PH_LOAD: begin
               r_phase <= PH_ITER;
               r_iter  <= ITER_LAST;
            end
            PH_ITER: begin
               if (r_iter == '0) r_phase <= PH_CAPT;
               else              r_iter  <= r_iter - 1'b1;
            end
            PH_CAPT:   r_phase <= PH_SAMPLE;
            // Chain directly into the next CLR so operations run back to back.
            PH_SAMPLE: r_phase <= i_last ? PH_IDLE : PH_CLR;
            default:   r_phase <= PH_IDLE;
         endcase
      end
   end

   assign o_sample   = (r_phase == PH_SAMPLE);
   assign o_mmm_ld_a = (r_phase == PH_LOAD);
   assign o_mmm_ld_r = (r_phase == PH_CAPT);
   assign o_mmm_lock = (r_phase != PH_CAPT);
   // The multiplier stays cleared whenever no operation is in flight.
   assign o_mmm_rst  = (r_phase != PH_IDLE) && (r_phase != PH_CLR);
   assign o_mmm_en   = i_en && ((r_phase == PH_LOAD) || (r_phase == PH_ITER));

endmodule

// File: rtl/mmm_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation C = X^E mod M in the
// Montgomery domain, driving an external bit-serial Montgomery multiplier.
module mmm_exp_ctrl
   import mmm_exp_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int EXP_WIDTH  = 8,
   parameter int MMM_CYCLES = WIDTH + 2
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 en,
   input  logic                 start,
   input  logic [WIDTH-1:0]     X,
   input  logic [EXP_WIDTH-1:0] E,
   input  logic [WIDTH-1:0]     M,
   input  logic [WIDTH-1:0]     R2,
   output logic [WIDTH-1:0]     C,
   output logic                 busy,
   output logic                 done,
   output logic                 mmm_en,
   output logic                 mmm_rst,
   output logic                 mmm_ld_a,
   output logic                 mmm_ld_r,
   output logic                 mmm_lock,
   output logic [WIDTH-1:0]     mmm_A,
   output logic [WIDTH-1:0]     mmm_B,
   input  logic [WIDTH-1:0]     mmm_R
);

   localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam logic [BW-1:0]    BIT_TOP = BW'(EXP_WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE     = ONE_MAX[WIDTH-1:0];

   logic [2:0]           r_state;
   logic [WIDTH-1:0]     r_x;
   logic [EXP_WIDTH-1:0] r_e;
   logic [WIDTH-1:0]     r_base;
   logic [WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]     r_c;
   logic [BW-1:0]        r_bit;

   logic w_go;
   logic w_last;
   logic w_sample;
   logic w_unused_m;

   // The modulus is wired to the multiplier elsewhere; this block never reads it.
   assign w_unused_m = ^M;

   assign w_go   = (r_state == ST_IDLE) && start;
   assign w_last = (r_state == ST_FROM_MONT);

   mmm_op_seq #(
      .MMM_CYCLES (MMM_CYCLES)
   ) u_op_seq (
      .i_clk      (clk),
      .i_rstb     (rstb),
      .i_en       (en),
      .i_go       (w_go),
      .i_last     (w_last),
      .o_sample   (w_sample),
      .o_mmm_en   (mmm_en),
      .o_mmm_rst  (mmm_rst),
      .o_mmm_ld_a (mmm_ld_a),
      .o_mmm_ld_r (mmm_ld_r),
      .o_mmm_lock (mmm_lock)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state <= ST_IDLE;
         r_x     <= '0;
         r_e     <= '0;
         r_base  <= '0;
         r_acc   <= '0;
         r_c     <= '0;
         r_bit   <= '0;
      end else if (en) begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_x     <= X;
                  r_e     <= E;
                  r_state <= ST_TO_MONT_X;
               end
            end
            ST_TO_MONT_X: begin
               if (w_sample) begin
                  r_base  <= mmm_R;
                  r_state <= ST_TO_MONT_ONE;
               end
            end
            ST_TO_MONT_ONE: begin
               if (w_sample) begin
                  r_acc   <= mmm_R;
                  r_bit   <= BIT_TOP;
                  r_state <= ST_SQUARE;
               end
            end
            ST_SQUARE: begin
               if (w_sample) begin
                  r_acc <= mmm_R;
                  if (r_e[r_bit]) begin
                     r_state <= ST_MULT;
                  end else if (r_bit == '0) begin
                     r_state <= ST_FROM_MONT;
                  end else begin
                     r_bit   <= r_bit - 1'b1;
                     r_state <= ST_SQUARE;
                  end
               end
            end
            ST_MULT: begin
               if (w_sample) begin
                  r_acc <= mmm_R;
                  if (r_bit == '0) begin
                     r_state <= ST_FROM_MONT;
                  end else begin
                     r_bit   <= r_bit - 1'b1;
                     r_state <= ST_SQUARE;
                  end
               end
            end
            ST_FROM_MONT: begin
               if (w_sample) begin
                  r_c     <= mmm_R;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Operands derive from registers that only change on SAMPLE, so they are
   // stable from CLR through CAPT of every multiplication.
   always_comb begin
      mmm_A = '0;
      mmm_B = '0;
      case (r_state)
         ST_TO_MONT_X:   begin mmm_A = r_x;   mmm_B = R2;     end
         ST_TO_MONT_ONE: begin mmm_A = ONE;   mmm_B = R2;     end
         ST_SQUARE:      begin mmm_A = r_acc; mmm_B = r_acc;  end
         ST_MULT:        begin mmm_A = r_acc; mmm_B = r_base; end
         ST_FROM_MONT:   begin mmm_A = r_acc; mmm_B = ONE;    end
         default:        begin mmm_A = '0;    mmm_B = '0;     end
      endcase
   end

   assign C    = r_c;
   assign done = (r_state == ST_DONE);
   assign busy = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_mmm_exp_ctrl.sv
// Directed bench for mmm_exp_ctrl with a behavioural Montgomery multiplier
// (A*B*16^-1 mod 13) answering at CAPT.
module tb_mmm_exp_ctrl;

   logic       clk = 1'b0;
   logic       rstb, en, start;
   logic [3:0] X, E, M, R2;
   logic [3:0] C, mmm_A, mmm_B;
   logic [3:0] mmm_R = 4'd0;
   logic       busy, done, mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock;

   int n_cmp = 0;
   int n_bad = 0;

   mmm_exp_ctrl #(.WIDTH(4), .EXP_WIDTH(4), .MMM_CYCLES(6)) dut (
      .clk(clk), .rstb(rstb), .en(en), .start(start),
      .X(X), .E(E), .M(M), .R2(R2), .C(C),
      .busy(busy), .done(done),
      .mmm_en(mmm_en), .mmm_rst(mmm_rst), .mmm_ld_a(mmm_ld_a),
      .mmm_ld_r(mmm_ld_r), .mmm_lock(mmm_lock),
      .mmm_A(mmm_A), .mmm_B(mmm_B), .mmm_R(mmm_R)
   );

   always #5 clk = ~clk;

   // 16^-1 mod 13 = 9
   always @(posedge clk)
      if (mmm_ld_r && !mmm_lock)
         mmm_R <= 4'((int'(mmm_A) * int'(mmm_B) * 9) % int'(M));

   task automatic do_start(input logic [3:0] x, input logic [3:0] e);
      X = x; E = e; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int lat, output int busy_low);
      lat = 0; busy_low = 0;
      while (done !== 1'b1 && lat < limit) begin
         if (busy !== 1'b1) busy_low++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rstb = 1'b0; en = 1'b1; start = 1'b0;
      X = 4'd0; E = 4'd0; M = 4'd13; R2 = 4'd9;
      #12;
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if (C !== 4'd0)        begin n_bad++; $display("FAIL reset_C: got %0d expected 0", C); end
      n_cmp++; if (mmm_rst !== 1'b0)  begin n_bad++; $display("FAIL reset_mmm_rst: got %b expected 0", mmm_rst); end
      n_cmp++; if (mmm_en !== 1'b0)   begin n_bad++; $display("FAIL reset_mmm_en: got %b expected 0", mmm_en); end
      n_cmp++; if (mmm_ld_a !== 1'b0) begin n_bad++; $display("FAIL reset_ld_a: got %b expected 0", mmm_ld_a); end
      n_cmp++; if (mmm_ld_r !== 1'b0) begin n_bad++; $display("FAIL reset_ld_r: got %b expected 0", mmm_ld_r); end
      n_cmp++; if (mmm_lock !== 1'b1) begin n_bad++; $display("FAIL reset_lock: got %b expected 1", mmm_lock); end
      n_cmp++; if (mmm_A !== 4'd0 || mmm_B !== 4'd0)
         begin n_bad++; $display("FAIL reset_operands: got A=%0d B=%0d expected 0 0", mmm_A, mmm_B); end
      @(posedge clk); #1;
      rstb = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int lat, blow;
      do_start(4'd5, 4'd3);
      wait_done(200, lat, blow);
      n_cmp++; if (lat != 90)   begin n_bad++; $display("FAIL basic_latency: got %0d expected 90", lat); end
      n_cmp++; if (blow != 0)   begin n_bad++; $display("FAIL basic_busy: busy low %0d cycles expected 0", blow); end
      n_cmp++; if (C !== 4'd8)  begin n_bad++; $display("FAIL basic_C: got %0d expected 8", C); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
      n_cmp++; if (C !== 4'd8)    begin n_bad++; $display("FAIL basic_C_hold: got %0d expected 8", C); end
   endtask

   task automatic test_exp_zero;
      int lat = 0, k = 0;
      do_start(4'd7, 4'd0);
      while (done !== 1'b1 && lat < 200) begin
         if (mmm_ld_a === 1'b1) begin
            k++;
            if (k == 1) begin
               n_cmp++; if (mmm_A !== 4'd7 || mmm_B !== 4'd9)
                  begin n_bad++; $display("FAIL ez_to_mont_x: got A=%0d B=%0d expected 7 9", mmm_A, mmm_B); end
            end
            if (k >= 3 && k <= 6) begin
               n_cmp++; if (mmm_A !== 4'd3 || mmm_B !== 4'd3)
                  begin n_bad++; $display("FAIL ez_square%0d: got A=%0d B=%0d expected 3 3", k, mmm_A, mmm_B); end
            end
            if (k == 7) begin
               n_cmp++; if (mmm_A !== 4'd3 || mmm_B !== 4'd1)
                  begin n_bad++; $display("FAIL ez_from_mont: got A=%0d B=%0d expected 3 1", mmm_A, mmm_B); end
            end
         end
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++; if (k != 7)     begin n_bad++; $display("FAIL ez_mult_count: got %0d expected 7", k); end
      n_cmp++; if (lat != 70)  begin n_bad++; $display("FAIL ez_latency: got %0d expected 70", lat); end
      n_cmp++; if (C !== 4'd1) begin n_bad++; $display("FAIL ez_C: got %0d expected 1", C); end
      @(posedge clk); #1;
   endtask

   task automatic test_phases;
      int n_rst = 0, n_lda = 0, n_iter = 0, n_ldr = 0, n_unlock = 0, n_moved = 0;
      int lat, blow;
      logic [3:0] a0, b0;
      logic rst_first, ldr_at_capt;
      do_start(4'd5, 4'd3);
      repeat (20) begin @(posedge clk); #1; end
      a0 = mmm_A; b0 = mmm_B;
      rst_first = ~mmm_rst;
      ldr_at_capt = 1'b0;
      for (int c = 21; c <= 30; c++) begin
         if (!mmm_rst) n_rst++;
         if (mmm_ld_a) n_lda++;
         if (mmm_en && !mmm_ld_a) n_iter++;
         if (mmm_ld_r) n_ldr++;
         if (!mmm_lock) n_unlock++;
         if (c == 29 && mmm_ld_r && !mmm_lock) ldr_at_capt = 1'b1;
         if (c <= 29 && (mmm_A !== a0 || mmm_B !== b0)) n_moved++;
         @(posedge clk); #1;
      end
      n_cmp++; if (a0 !== 4'd3 || b0 !== 4'd3)
         begin n_bad++; $display("FAIL ph_operands: got A=%0d B=%0d expected 3 3", a0, b0); end
      n_cmp++; if (rst_first !== 1'b1) begin n_bad++; $display("FAIL ph_clr_first: got %b expected 1", rst_first); end
      n_cmp++; if (n_rst != 1)    begin n_bad++; $display("FAIL ph_rst_cycles: got %0d expected 1", n_rst); end
      n_cmp++; if (n_lda != 1)    begin n_bad++; $display("FAIL ph_ld_a_cycles: got %0d expected 1", n_lda); end
      n_cmp++; if (n_iter != 6)   begin n_bad++; $display("FAIL ph_iter_cycles: got %0d expected 6", n_iter); end
      n_cmp++; if (n_ldr != 1)    begin n_bad++; $display("FAIL ph_ld_r_cycles: got %0d expected 1", n_ldr); end
      n_cmp++; if (n_unlock != 1) begin n_bad++; $display("FAIL ph_unlock_cycles: got %0d expected 1", n_unlock); end
      n_cmp++; if (ldr_at_capt !== 1'b1) begin n_bad++; $display("FAIL ph_capt_slot: got %b expected 1", ldr_at_capt); end
      n_cmp++; if (n_moved != 0)  begin n_bad++; $display("FAIL ph_operand_stable: got %0d changes expected 0", n_moved); end
      wait_done(200, lat, blow);
      n_cmp++; if (lat != 60 || C !== 4'd8)
         begin n_bad++; $display("FAIL ph_finish: got lat=%0d C=%0d expected 60 8", lat, C); end
      @(posedge clk); #1;
   endtask

   task automatic test_en_freeze;
      int lat, blow, n_frozen_bad = 0;
      logic [3:0] a0, b0;
      logic rst0, lda0, ldr0, lock0;
      do_start(4'd5, 4'd3);
      repeat (24) begin @(posedge clk); #1; end
      a0 = mmm_A; b0 = mmm_B; rst0 = mmm_rst; lda0 = mmm_ld_a; ldr0 = mmm_ld_r; lock0 = mmm_lock;
      en = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         if (mmm_en !== 1'b0 || mmm_A !== a0 || mmm_B !== b0 || mmm_rst !== rst0 ||
             mmm_ld_a !== lda0 || mmm_ld_r !== ldr0 || mmm_lock !== lock0 || busy !== 1'b1)
            n_frozen_bad++;
         @(posedge clk); #1;
      end
      en = 1'b1;
      #1;
      n_cmp++; if (n_frozen_bad != 0) begin n_bad++; $display("FAIL frz_hold: got %0d bad cycles expected 0", n_frozen_bad); end
      n_cmp++; if (mmm_en !== 1'b1)   begin n_bad++; $display("FAIL frz_resume_en: got %b expected 1", mmm_en); end
      wait_done(200, lat, blow);
      n_cmp++; if (24 + 5 + lat != 95) begin n_bad++; $display("FAIL frz_latency: got %0d expected 95", 24 + 5 + lat); end
      n_cmp++; if (C !== 4'd8)         begin n_bad++; $display("FAIL frz_C: got %0d expected 8", C); end
      @(posedge clk); #1;
      // start while en is low must be dropped
      en = 1'b0;
      do_start(4'd2, 4'd5);
      en = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL frz_start_en_low: got busy=%b expected 0", busy); end
   endtask

   task automatic test_back_to_back;
      int lat, blow, n_spur = 0;
      do_start(4'd5, 4'd3);
      repeat (29) begin @(posedge clk); #1; end
      do_start(4'd2, 4'd5);
      wait_done(200, lat, blow);
      n_cmp++; if (30 + lat != 90) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 90", 30 + lat); end
      n_cmp++; if (C !== 4'd8)     begin n_bad++; $display("FAIL b2b_ignored_start: got C=%0d expected 8", C); end
      @(posedge clk); #1;
      do_start(4'd2, 4'd5);
      repeat (39) begin @(posedge clk); #1; end
      n_cmp++; if (C !== 4'd8 || busy !== 1'b1)
         begin n_bad++; $display("FAIL b2b_mid_run: got C=%0d busy=%b expected 8 1", C, busy); end
      #2 rstb = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || C !== 4'd0)
         begin n_bad++; $display("FAIL b2b_reset: got busy=%b done=%b C=%0d expected 0 0 0", busy, done, C); end
      n_cmp++; if (mmm_rst !== 1'b0 || mmm_lock !== 1'b1 || mmm_en !== 1'b0)
         begin n_bad++; $display("FAIL b2b_reset_mmm: got rst=%b lock=%b en=%b expected 0 1 0", mmm_rst, mmm_lock, mmm_en); end
      @(posedge clk); @(posedge clk); #1;
      rstb = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) n_spur++;
         @(posedge clk); #1;
      end
      n_cmp++; if (n_spur != 0) begin n_bad++; $display("FAIL b2b_no_done: got %0d active cycles expected 0", n_spur); end
      do_start(4'd2, 4'd5);
      wait_done(200, lat, blow);
      n_cmp++; if (lat != 90)  begin n_bad++; $display("FAIL b2b_fresh_latency: got %0d expected 90", lat); end
      n_cmp++; if (C !== 4'd6) begin n_bad++; $display("FAIL b2b_fresh_C: got %0d expected 6", C); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_exp_zero();
      test_phases();
      test_en_freeze();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
